// File: rtl/bin_act_packer.sv
// Packs binary neuron results into activation bytes and queues them in a 16-entry FWFT FIFO.
// Define BIN_PACK_MSB_FIRST_EN to place the first result of each byte in bit 7 instead of bit 0.
module bin_act_packer (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [7:0]  neuron_out,
    input  logic        neuron_valid,
    input  logic [15:0] vec_length,
    input  logic        ovf_clear,
    output logic [7:0]  act_out,
    output logic        act_last,
    output logic        act_valid,
    input  logic        act_ready,
    output logic        pack_ready,
    output logic        ovf
);

    typedef enum logic {FILL, FLUSH} state_t;

    state_t      state;
    logic [2:0]  bit_cnt;
    logic [15:0] vec_cnt;
    logic [15:0] len_q;
    logic [7:0]  acc;

    logic [8:0]  mem [0:15];
    logic [3:0]  wr_ptr;
    logic [3:0]  rd_ptr;
    logic [4:0]  count;

    logic [15:0] len_cur;
    logic [15:0] len_eff;
    logic        vec_done;
    logic        byte_done;
    logic [2:0]  pos;
    logic [7:0]  acc_next;
    logic        push;
    logic        pop;
    logic        full;
    logic        wr_en;
    logic        drop;
    logic        unused_bits;

    assign unused_bits = ^neuron_out[7:1];

    // The length is latched on the first result, so use the live input for that one.
    always_comb begin
        len_cur = (vec_cnt == 16'd0) ? vec_length : len_q;
        len_eff = (len_cur == 16'd0) ? 16'd1 : len_cur;
    end

    assign vec_done  = (vec_cnt == len_eff - 16'd1);
    assign byte_done = (bit_cnt == 3'd7) || vec_done;

`ifdef BIN_PACK_MSB_FIRST_EN
    assign pos = 3'd7 - bit_cnt;
`else
    assign pos = bit_cnt;
`endif

    assign acc_next = acc | (neuron_out[0] ? (8'h01 << pos) : 8'h00);

    assign act_valid  = (count != 5'd0);
    assign pop        = act_valid && act_ready;
    assign full       = (count == 5'd16);
    assign push       = neuron_valid && byte_done;
    assign wr_en      = push && (!full || pop);
    assign drop       = push && full && !pop;
    assign pack_ready = (count <= 5'd14);
    assign act_out    = act_valid ? mem[rd_ptr][7:0] : 8'h00;
    assign act_last   = act_valid ? mem[rd_ptr][8] : 1'b0;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state   <= FILL;
            bit_cnt <= 3'd0;
            vec_cnt <= 16'd0;
            len_q   <= 16'd0;
            acc     <= 8'h00;
        end else begin
            if (neuron_valid && vec_cnt == 16'd0)
                len_q <= vec_length;
            if (push) begin
                state   <= FLUSH;
                bit_cnt <= 3'd0;
                vec_cnt <= vec_done ? 16'd0 : vec_cnt + 16'd1;
                acc     <= 8'h00;
            end else if (neuron_valid) begin
                state   <= FILL;
                bit_cnt <= bit_cnt + 3'd1;
                vec_cnt <= vec_cnt + 16'd1;
                acc     <= acc_next;
            end else begin
                state   <= FILL;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (wr_en)
            mem[wr_ptr] <= {vec_done, acc_next};
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= 4'd0;
            rd_ptr <= 4'd0;
            count  <= 5'd0;
            ovf    <= 1'b0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + 4'd1;
            if (pop)
                rd_ptr <= rd_ptr + 4'd1;
            if (wr_en && !pop)
                count <= count + 5'd1;
            else if (!wr_en && pop)
                count <= count - 5'd1;
            if (drop)
                ovf <= 1'b1;
            else if (ovf_clear)
                ovf <= 1'b0;
        end
    end

    // A flush cycle always starts a fresh byte.
    a_flush_fresh: assert property (@(posedge sys_clk) disable iff (sys_rst)
        state == FLUSH |-> (bit_cnt == 3'd0 && acc == 8'h00));

endmodule
